photocell_conditioner: RTL and testbench
========================================

# photocell_conditioner

Input conditioning stage directly upstream of the bank queue counter. It takes the two raw, active-low photocell lines: entry cell `phcOne` and exit cell `phcTwo`. Each line is synchronised and debounced, and the block emits exactly one single-cycle `enter_pulse`/`leave_pulse` per person passage. The queue counter consumes only these pulses. An optional stuck-sensor detector flags a cell that stays blocked too long.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before the debounced state changes; legal range 2..65535.
- `STUCK_CYCLES`, default 50_000: cycles a debounced cell may stay blocked before its fault bit sets; must exceed `DEBOUNCE_CYCLES`.
- `FPGA_clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `phcOne` input 1: raw entry photocell; 0 = beam blocked; asynchronous to `FPGA_clk`.
- `phcTwo` input 1: raw exit photocell; same convention.
- `enter_pulse` output 1: one-cycle strobe per debounced 1→0 transition of `phcOne`.
- `leave_pulse` output 1: one-cycle strobe per debounced 1→0 transition of `phcTwo`.
- `phcOne_clean` output 1: debounced level of `phcOne`.
- `phcTwo_clean` output 1: debounced level of `phcTwo`.
- `phc_fault` output 2: bit0 = `phcOne` stuck blocked, bit1 = `phcTwo` stuck blocked.

## Operation
- Two identical, fully independent channels: raw → 2-FF synchroniser → debounce → edge detect → optional stuck timer.
- Reset values:
  - Synchroniser FFs: 0.
  - Clean levels: 0, treated as "blocked/unknown".
  - Debounce counters and stuck counters: 0.
  - Pulses: 0.
  - `phc_fault`: 0.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES)`:
  - Clears on any cycle where the synchronised sample equals the clean level.
  - Otherwise increments.
  - When it would reach `DEBOUNCE_CYCLES`, the clean level takes the sample value and the counter clears.
- A run of differing samples shorter than `DEBOUNCE_CYCLES` is discarded; there is no partial credit across interruptions.
- Pulse generation:
  - A pulse is generated only on a clean 1→0 transition.
  - 0→1 transitions (beam released) produce no pulse.
  - Because clean resets to 0, a cell held blocked through reset produces no pulse. Its first pulse requires a debounced release followed by a debounced block.
- Simultaneous events: both channels may pulse in the same cycle; both are emitted and nothing is queued or arbitrated.
- Stuck timer:
  - Counts while the clean level is 0 and saturates at `STUCK_CYCLES`.
  - Clears when the clean level is 1.
  - The fault bit is set while the counter equals `STUCK_CYCLES`.
- A fault never retracts or adds pulses.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight debounce is abandoned and no pulse is generated.

## Timing
- Raw edge to clean-level change and pulse: exactly `DEBOUNCE_CYCLES + 2` rising edges after the raw level settles, provided it stays stable (2 synchroniser edges + `DEBOUNCE_CYCLES`).
- `enter_pulse`/`leave_pulse` are registered:
  - They assert on the same edge at which the corresponding clean level falls.
  - They stay high exactly one `FPGA_clk` cycle.
- Minimum spacing between two pulses on one channel: `2*DEBOUNCE_CYCLES` cycles.
- Fault latency: `phc_fault[i]` rises `STUCK_CYCLES` edges after the clean level fell. It falls on the same edge the clean level rises.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `PHC_STUCK_DETECT_EN`.
- Defined: stuck counters and fault logic are present, as above.
- Undefined:
  - Stuck counters are not instantiated.
  - `phc_fault` is tied to 2'b00.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STUCK_CYCLES`=20.
- Reset release, `phcOne`=`phcTwo`=1: both clean levels rise at edge 6 after reset release; no pulses; `phc_fault`=00.
- `phcOne` driven 0 for 12 cycles after settling: `enter_pulse` high for exactly 1 cycle, at edge 6 after the fall; `phcOne_clean`=0. After release, clean returns to 1 at edge 6 with no pulse.
- 3-cycle low glitch on `phcTwo`: no `leave_pulse`; `phcTwo_clean` stays 1.
- Both cells driven 0 on the same edge: `enter_pulse` and `leave_pulse` high in the same cycle, once each.
- With `PHC_STUCK_DETECT_EN`, `phcOne` held 0 for 40 cycles:
  - One `enter_pulse`.
  - `phc_fault[0]` rises 20 edges after the clean level falls.
  - Fault clears on the edge the clean level returns to 1.
  - Without the macro, `phc_fault` stays 00 throughout.
- `phcOne` held 0 through reset, then reset released: no pulse. A later release, followed by a block, yields exactly one pulse.
- Reset asserted 2 cycles into a debounce: no pulse, and the clean level stays 0.

Source files
------------

// File: rtl/photocell_conditioner.sv
// photocell_conditioner: synchronise, debounce and edge-detect two active-low photocells; optional stuck detector (PHC_STUCK_DETECT_EN)
module photocell_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES = 50_000
) (
  input  logic       FPGA_clk,
  input  logic       reset,
  input  logic       phcOne,
  input  logic       phcTwo,
  output logic       enter_pulse,
  output logic       leave_pulse,
  output logic       phcOne_clean,
  output logic       phcTwo_clean,
  output logic [1:0] phc_fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] raw, s1, s2, clean, clean_next, hit, pulse;
  logic [DW-1:0] cnt [2];
  assign raw = {phcTwo, phcOne};
  assign hit = (s2 ^ clean) & {cnt[1] == DMAX, cnt[0] == DMAX};
  assign clean_next = (clean & ~hit) | (s2 & hit);
  // synchroniser, debounce window and falling-edge strobe for both channels
  always_ff @(posedge FPGA_clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      clean <= '0;
      pulse <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= raw;
      s2 <= s1;
      clean <= clean_next;
      pulse <= hit & clean;
      for (int i = 0; i < 2; i++) cnt[i] <= (s2[i] == clean[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end
  assign enter_pulse = pulse[0];
  assign leave_pulse = pulse[1];
  assign phcOne_clean = clean[0];
  assign phcTwo_clean = clean[1];
`ifdef PHC_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STUCK_CYCLES);
  localparam logic [SW-1:0] SPRE = SW'(STUCK_CYCLES - 1);
  logic [SW-1:0] stk [2];
  logic [1:0] fault;
  // blocked-time counters; fault drops on the same edge the clean level rises
  always_ff @(posedge FPGA_clk or posedge reset)
    if (reset) begin
      stk <= '{default: '0};
      fault <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        stk[i] <= clean[i] ? '0 : (stk[i] == SMAX ? stk[i] : stk[i] + 1'b1);
        fault[i] <= ~clean_next[i] & (stk[i] >= SPRE);
      end
    end
  assign phc_fault = fault;
`else
  assign phc_fault = 2'b00;
`endif
endmodule

// File: tb/tb_photocell_conditioner.sv
// tb_photocell_conditioner: scenario tasks plus randomized run against a behavioural photocell model
module tb_photocell_conditioner;
  localparam int DB = 4;
  localparam int ST = 20;
`ifdef PHC_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif
  logic clk = 1'b0, rst, phcOne, phcTwo;
  logic enter_pulse, leave_pulse, phcOne_clean, phcTwo_clean;
  logic [1:0] phc_fault;
  int tests = 0, fails = 0;
  logic [1:0] dq [$];
  logic [1:0] m_clean, m_pulse, m_fault;
  int run [2];
  int age [2];
  wire [5:0] obs = {enter_pulse, leave_pulse, phcTwo_clean, phcOne_clean, phc_fault};
  wire [5:0] mdl = {m_pulse[0], m_pulse[1], m_clean[1], m_clean[0], m_fault};

  photocell_conditioner #(.DEBOUNCE_CYCLES(DB), .STUCK_CYCLES(ST)) dut (
    .FPGA_clk(clk), .reset(rst), .phcOne(phcOne), .phcTwo(phcTwo),
    .enter_pulse(enter_pulse), .leave_pulse(leave_pulse),
    .phcOne_clean(phcOne_clean), .phcTwo_clean(phcTwo_clean), .phc_fault(phc_fault)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    dq = {2'b00, 2'b00};
    m_clean = '0;
    m_pulse = '0;
    m_fault = '0;
    for (int i = 0; i < 2; i++) begin
      run[i] = 0;
      age[i] = 0;
    end
  endtask

  // a raw value reaches the debouncer two edges late; the clean level takes
  // a value once it has been seen DB edges running, and a fall strobes a pulse
  task automatic model_step(input logic [1:0] r);
    logic [1:0] samp;
    samp = dq.pop_front();
    dq.push_back(r);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      run[i] = (samp[i] != m_clean[i]) ? run[i] + 1 : 0;
      if (run[i] == DB) begin
        m_pulse[i] = m_clean[i] & ~samp[i];
        m_clean[i] = samp[i];
        run[i] = 0;
        age[i] = 0;
      end else if (!m_clean[i]) age[i]++;
      m_fault[i] = STUCK_EN && !m_clean[i] && age[i] >= ST;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step({phcTwo, phcOne});
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; phcOne = 1'b1; phcTwo = 1'b1;
    model_reset();
    repeat (3) cycle();
    tests++; if (obs !== 6'b0) begin fails++; $display("FAIL reset_state got %b exp 000000", obs); end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tests++; if (obs !== mdl) begin fails++; $display("FAIL reset_model k=%0d got %b exp %b", k, obs, mdl); end
      tests++; if ({phcTwo_clean, phcOne_clean} !== (k >= 6 ? 2'b11 : 2'b00)) begin fails++; $display("FAIL reset_rise k=%0d got %b%b", k, phcTwo_clean, phcOne_clean); end
    end
  endtask

  task automatic test_enter();
    phcOne = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      tests++; if (obs !== mdl) begin fails++; $display("FAIL enter_model k=%0d got %b exp %b", k, obs, mdl); end
      tests++; if (enter_pulse !== (k == 6)) begin fails++; $display("FAIL enter_pulse k=%0d got %b", k, enter_pulse); end
    end
    tests++; if (phcOne_clean !== 1'b0) begin fails++; $display("FAIL enter_clean got %b exp 0", phcOne_clean); end
    phcOne = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      tests++; if ({enter_pulse, phcOne_clean} !== {1'b0, k >= 6}) begin fails++; $display("FAIL release k=%0d got %b%b", k, enter_pulse, phcOne_clean); end
    end
  endtask

  task automatic test_glitch();
    phcTwo = 1'b0;
    repeat (3) cycle();
    phcTwo = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      tests++; if ({leave_pulse, phcTwo_clean} !== 2'b01 || obs !== mdl) begin fails++; $display("FAIL glitch k=%0d got %b exp %b", k, obs, mdl); end
    end
  endtask

  task automatic test_back_to_back();
    phcOne = 1'b0; phcTwo = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tests++; if ({enter_pulse, leave_pulse} !== (k == 6 ? 2'b11 : 2'b00)) begin fails++; $display("FAIL both k=%0d got %b%b", k, enter_pulse, leave_pulse); end
    end
    phcOne = 1'b1; phcTwo = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      tests++; if (obs !== mdl) begin fails++; $display("FAIL both_release k=%0d got %b exp %b", k, obs, mdl); end
    end
  endtask

  task automatic test_stuck();
    int np = 0;
    phcOne = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      np += enter_pulse;
      tests++; if (phc_fault !== {1'b0, STUCK_EN && k >= 6 + ST}) begin fails++; $display("FAIL stuck_rise k=%0d got %b", k, phc_fault); end
    end
    tests++; if (np != 1) begin fails++; $display("FAIL stuck_pulses got %0d exp 1", np); end
    phcOne = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      tests++; if ({phcOne_clean, phc_fault} !== {k >= 6, 1'b0, STUCK_EN && k < 6}) begin fails++; $display("FAIL stuck_clear k=%0d got %b%b", k, phcOne_clean, phc_fault); end
    end
  endtask

  task automatic test_reset_blocked();
    int np = 0;
    phcOne = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      tests++; if ({enter_pulse, phcOne_clean} !== 2'b00 || obs !== mdl) begin fails++; $display("FAIL held_reset k=%0d got %b exp %b", k, obs, mdl); end
    end
    phcOne = 1'b1;
    repeat (10) cycle();
    phcOne = 1'b0;
    repeat (10) begin
      cycle();
      np += enter_pulse;
    end
    tests++; if (np != 1) begin fails++; $display("FAIL held_reset_pulse got %0d exp 1", np); end
  endtask

  task automatic test_reset_mid();
    phcOne = 1'b0;
    repeat (4) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++; if (obs !== 6'b0) begin fails++; $display("FAIL mid_reset_async got %b exp 000000", obs); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      tests++; if ({enter_pulse, phcOne_clean} !== 2'b00 || obs !== mdl) begin fails++; $display("FAIL mid_reset k=%0d got %b exp %b", k, obs, mdl); end
    end
  endtask

  task automatic test_random();
    int hold [2] = '{0, 0};
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          hold[i] = $urandom_range(1, 12);
          if (i == 0) phcOne = $urandom_range(0, 1); else phcTwo = $urandom_range(0, 1);
        end
        hold[i]--;
      end
      cycle();
      tests++; if (obs !== mdl) begin fails++; $display("FAIL random n=%0d got %b exp %b", n, obs, mdl); end
    end
  endtask

  initial begin
    test_reset();
    test_enter();
    test_glitch();
    test_back_to_back();
    test_stuck();
    test_reset_blocked();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
